// File: rtl/cache_fill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_fill_pkg                                                       |
// | Shared types and constants for the cache block fill controller.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cache_fill_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;
    localparam int unsigned WORD_BYTES      = 2;

    // One extra bit so a counter can hold the value WORDS_PER_BLOCK itself.
    function automatic int unsigned cnt_width(input int unsigned words);
        return $clog2(words) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fill_fsm_fill_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fill_counter                                                         |
// | Word counter with enable, sync clear and terminal flag.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fill_counter
    import cache_fill_pkg::*;
#(
    parameter int unsigned TERMINAL = WORDS_PER_BLOCK,
    parameter int unsigned CNT_W    = cnt_width(TERMINAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign done = (r_cnt == CNT_W'(TERMINAL));

endmodule
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_fill_fsm                                                       |
// | Cache miss handler: bursts a block from memory into the cache.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cache_fill_fsm #(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] cache_address,
    output logic [ADDR_W-1:0] cache_data,
    output logic              memory_read,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [ADDR_W-1:0] memory_data
);

    import cache_fill_pkg::*;

    localparam int unsigned      CNT_W    = cnt_width(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;

    logic                w_in_fill;
    logic                w_start;
    logic                w_issue_en;
    logic                w_issue_done;
    logic [CNT_W-1:0]    w_issue_cnt;
    logic [CNT_W-1:0]    w_issue_idx;
    logic                w_recv_en;
    logic                w_recv_done;
    logic [CNT_W-1:0]    w_recv_cnt;
    logic                w_last;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic [ADDR_W-1:0]   w_recv_addr;

    assign w_in_fill  = (r_state == FILL);
    assign w_start    = (r_state == IDLE) && miss_detected;
    assign w_issue_en = w_in_fill && !w_issue_done;
    // Responses arriving while idle are stale and simply dropped.
    assign w_recv_en  = w_in_fill && memory_data_valid && !w_recv_done;
    assign w_last     = w_recv_en && (w_recv_cnt == LAST_IDX);

    fill_counter #(
        .TERMINAL (WORDS_PER_BLOCK),
        .CNT_W    (CNT_W)
    ) u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_start),
        .en   (w_issue_en),
        .cnt  (w_issue_cnt),
        .done (w_issue_done)
    );

    fill_counter #(
        .TERMINAL (WORDS_PER_BLOCK),
        .CNT_W    (CNT_W)
    ) u_recv_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_start),
        .en   (w_recv_en),
        .cnt  (w_recv_cnt),
        .done (w_recv_done)
    );

    // After the last request the address parks on the final word of the block.
    assign w_issue_idx  = w_issue_done ? LAST_IDX : w_issue_cnt;
    assign w_issue_addr = r_base + (ADDR_W'(w_issue_idx) * ADDR_W'(WORD_BYTES));
    assign w_recv_addr  = r_base + (ADDR_W'(w_recv_cnt) * ADDR_W'(WORD_BYTES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_base  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_detected) begin
                        r_base  <= miss_address & ADDR_W'(BLOCK_MASK);
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The stall must start in the miss cycle itself, so busy is not registered.
    assign fsm_busy         = w_in_fill || (miss_detected && rst);
    assign memory_read      = w_issue_en;
    assign memory_address   = w_in_fill ? w_issue_addr : '0;
    assign write_data_array = w_recv_en;
    assign write_tag_array  = w_last;
    assign cache_address    = w_recv_en ? w_recv_addr : '0;
    assign cache_data       = w_recv_en ? memory_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_fill_fsm                                                    |
// | Directed scoreboard bench for the cache block fill controller.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_address;
    logic [15:0] cache_data;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;

    cache_fill_fsm #(
        .ADDR_W          (16),
        .WORDS_PER_BLOCK (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_address     (cache_address),
        .cache_data        (cache_data),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
        logic        t;
    } wr_t;

    logic [15:0] exp_rd[$];
    wr_t         exp_wr[$];
    int          checks = 0;
    int          errors = 0;
    int          vc[8];
    wr_t         mon_e;
    logic [15:0] mon_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got event with value %h, expected none at %0t", name, act, $time);
    endtask

    // Drive one cycle of inputs just after the edge, return at mid-cycle.
    task automatic tick(input logic r, input logic m, input logic [15:0] ma,
                        input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst               = r;
        miss_detected     = m;
        miss_address      = ma;
        memory_data_valid = v;
        memory_data       = d;
        @(negedge clk);
    endtask

    // Monitor: every presented read or write must match the head of its queue.
    always @(negedge clk) begin
        if (memory_read) begin
            if (exp_rd.size() == 0) begin
                unexp("unexpected_read", {16'h0, memory_address});
            end else begin
                mon_a = exp_rd.pop_front();
                chk("read_addr", {16'h0, memory_address}, {16'h0, mon_a});
            end
        end
        if (write_data_array) begin
            if (exp_wr.size() == 0) begin
                unexp("unexpected_write", {16'h0, cache_address});
            end else begin
                mon_e = exp_wr.pop_front();
                chk("write_addr", {16'h0, cache_address}, {16'h0, mon_e.a});
                chk("write_data", {16'h0, cache_data}, {16'h0, mon_e.d});
                chk("write_tag", {31'h0, write_tag_array}, {31'h0, mon_e.t});
            end
        end else if (write_tag_array) begin
            unexp("tag_without_data", 32'h1);
        end
    end

    // Miss on cycle 0, valids on cycles vc[0..7]; returns after the tag cycle.
    task automatic run_fill(input logic [15:0] maddr, input logic [15:0] base,
                            input logic [15:0] dbase, input logic hold,
                            input logic [15:0] alt);
        int   vk;
        logic v;
        vk = 0;
        for (int k = 0; k < 8; k++) begin
            exp_rd.push_back(base + 16'(2 * k));
            exp_wr.push_back('{a: base + 16'(2 * k), d: dbase + 16'(k), t: (k == 7)});
        end
        tick(1'b1, 1'b1, maddr, 1'b0, 16'h0);
        chk("busy_on_miss", {31'h0, fsm_busy}, 32'h1);
        chk("no_read_in_miss_cycle", {31'h0, memory_read}, 32'h0);
        for (int c = 1; c <= vc[7]; c++) begin
            v = (vk < 8) && (vc[vk] == c);
            tick(1'b1, hold, hold ? alt : 16'h0, v, v ? dbase + 16'(vk) : 16'h0);
            chk("busy_in_fill", {31'h0, fsm_busy}, 32'h1);
            chk("tag_timing", {31'h0, write_tag_array}, {31'h0, (c == vc[7])});
            if (c == 10) begin
                chk("read_stopped", {31'h0, memory_read}, 32'h0);
                chk("addr_hold", {16'h0, memory_address}, {16'h0, base + 16'hE});
            end
            if (v) vk++;
        end
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_reads_done"}, exp_rd.size(), 32'h0);
        chk({tag, "_writes_done"}, exp_wr.size(), 32'h0);
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, {31'h0, fsm_busy}, 32'h0);
        chk({tag, "_wda"}, {31'h0, write_data_array}, 32'h0);
        chk({tag, "_wta"}, {31'h0, write_tag_array}, 32'h0);
        chk({tag, "_mrd"}, {31'h0, memory_read}, 32'h0);
        chk({tag, "_caddr"}, {16'h0, cache_address}, 32'h0);
        chk({tag, "_cdata"}, {16'h0, cache_data}, 32'h0);
        chk({tag, "_maddr"}, {16'h0, memory_address}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'h1234;
        memory_data_valid = 1'b1;
        memory_data       = 16'hFFFF;

        // Reset holds everything at zero even with live inputs.
        tick(1'b0, 1'b1, 16'h1234, 1'b1, 16'hFFFF);
        all_zero("reset");

        // Single miss, latency 4.
        vc = '{5, 6, 7, 8, 9, 10, 11, 12};
        run_fill(16'h1234, 16'h1230, 16'hA000, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("t1_busy_drop", {31'h0, fsm_busy}, 32'h0);
        queues_empty("t1");

        // Irregular response gaps.
        vc = '{3, 5, 8, 10, 14, 16, 19, 21};
        run_fill(16'h5678, 16'h5670, 16'h5A00, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("t2_busy_drop", {31'h0, fsm_busy}, 32'h0);
        queues_empty("t2");

        // Miss held high, address changes mid-fill; second fill follows at once.
        vc = '{5, 6, 7, 8, 9, 10, 11, 12};
        run_fill(16'h1234, 16'h1230, 16'hB000, 1'b1, 16'hABCD);
        run_fill(16'hABCD, 16'hABC0, 16'hC000, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("t3_busy_drop", {31'h0, fsm_busy}, 32'h0);
        queues_empty("t3");

        // Reset in cycle 6 of a fill.
        for (int k = 0; k < 5; k++) exp_rd.push_back(16'h2000 + 16'(2 * k));
        exp_wr.push_back('{a: 16'h2000, d: 16'h7777, t: 1'b0});
        tick(1'b1, 1'b1, 16'h2000, 1'b0, 16'h0);
        for (int c = 1; c <= 4; c++) tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0, 1'b1, 16'h7777);
        tick(1'b0, 1'b0, 16'h0, 1'b1, 16'h8888);
        all_zero("midfill_reset");
        tick(1'b0, 1'b0, 16'h0, 1'b1, 16'h8889);
        for (int c = 8; c <= 10; c++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b1, 16'h9000 + 16'(c));
            chk("post_reset_busy", {31'h0, fsm_busy}, 32'h0);
            chk("post_reset_wda", {31'h0, write_data_array}, 32'h0);
        end
        queues_empty("t4");

        // Stale valids while idle.
        for (int c = 0; c < 4; c++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b1, 16'h4400 + 16'(c));
            chk("idle_busy", {31'h0, fsm_busy}, 32'h0);
            chk("idle_wda", {31'h0, write_data_array}, 32'h0);
            chk("idle_wta", {31'h0, write_tag_array}, 32'h0);
        end

        // Top-of-memory block.
        vc = '{5, 6, 7, 8, 9, 10, 11, 12};
        run_fill(16'hFFFE, 16'hFFF0, 16'h3300, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("t6_busy_drop", {31'h0, fsm_busy}, 32'h0);
        queues_empty("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
